spike_monitor: RTL and testbench
================================

SPIKE_MONITOR -- requirements
Module: spike_monitor

Interface
REQ-001 SHALL have parameter WIN_LEN, default 100, meaning window length in clock cycles (legal 2..255).
REQ-002 SHALL have parameter BURST_ISI, default 4, meaning ISI threshold below which a spike pair is a burst (legal 1..254).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port spike  input  1  neuron spike output; may stay high for more than one cycle.
REQ-006 SHALL have port state  input  8  neuron membrane state, unsigned.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the window result this cycle.
REQ-008 SHALL have port out_valid  output  1  window result pending.
REQ-009 SHALL have port rate_out  output  8  spike count of the completed window.
REQ-010 SHALL have port peak_out  output  8  maximum state sampled in the completed window.
REQ-011 SHALL have port isi_out  output  8  most recent inter-spike interval in cycles, saturating at 255.
REQ-012 SHALL have port isi_valid  output  1  isi_out holds a measured interval.
REQ-013 SHALL have port burst  output  1  single-cycle pulse on a spike event whose ISI is less than BURST_ISI.
REQ-014 SHALL have port overrun  output  1  sticky flag: a pending result was overwritten.

Function
REQ-015 A spike event SHALL be the rising edge of spike (spike=1 and the registered previous spike=0); held-high cycles SHALL NOT count again.
REQ-016 The window counter SHALL count 0..WIN_LEN-1 and wrap; the cycle where it equals WIN_LEN-1 is the window-end cycle.
REQ-017 The spike counter SHALL increment per event and saturate at 255; it and the peak register SHALL include the window-end cycle's event/sample.
REQ-018 The peak register SHALL track max(state) over every cycle of the window, using unsigned compare.
REQ-019 On window-end: rate_out and peak_out SHALL load the final values, out_valid SHALL be 1 the next cycle, the spike counter SHALL restart at 0, and the peak register SHALL restart at 0.
REQ-020 The handshake SHALL complete when out_valid and out_ready are both 1; out_valid SHALL then clear the next cycle unless a window-end coincides.
REQ-021 rate_out and peak_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 If window-end occurs while out_valid=1 and no handshake completes that cycle, new values SHALL overwrite, out_valid SHALL stay 1, and overrun SHALL set.
REQ-023 If window-end and a handshake occur in the same cycle, new values SHALL load, out_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-024 The ISI FSM SHALL have states NO_SPIKE (reset) and TIMING; the first event SHALL move NO_SPIKE to TIMING with the interval counter at 1 the next cycle.
REQ-025 In TIMING, the interval counter SHALL increment each cycle, saturate at 255, and reload to 1 on an event.
REQ-026 In TIMING, each event SHALL load isi_out with the counter value and set isi_valid=1 the next cycle; isi_valid SHALL stay 1 until reset.
REQ-027 burst SHALL pulse for one cycle, aligned with the isi_out update, when the captured ISI is less than BURST_ISI; it SHALL never fire on the first event after reset.
REQ-028 Window and ISI logic SHALL run independently; the window boundary SHALL NOT reset the ISI measurement.

Reset
REQ-029 While rst=1, all counters, the FSM (NO_SPIKE), the previous-spike register, and all outputs SHALL clear to 0 on the clock edge.
REQ-030 A reset mid-window SHALL discard the partial window; counting SHALL restart at window count 0 on the first cycle with rst=0.
REQ-031 An event on the first cycle after reset SHALL be detected, with the previous-spike register taken as 0.

Verification
REQ-032 WIN_LEN=10, out_ready=1, spike pulses at cycles 2, 5 and 9 -> out_valid=1 at cycle 10 with rate_out=3; next window rate_out=0.
REQ-033 spike held high for 6 cycles -> exactly 1 event is counted and burst=0.
REQ-034 events 3 cycles apart, BURST_ISI=4 -> isi_out=3 and burst pulses one cycle; events 300 cycles apart -> isi_out=255, burst=0.
REQ-035 out_ready=0 across two window-ends -> overrun=1, outputs show the second window, out_valid=1; handshake held off exactly on a window-end cycle -> overrun=0.
REQ-036 state ramps 0..200 then falls within one window -> peak_out=200; next window peak_out reflects only that window's samples.
REQ-037 rst asserted mid-window with 4 spikes counted -> all outputs 0; the following full window reports only post-reset spikes.

Source files
------------

// File: rtl/spike_monitor.sv
// spike_monitor -- windowed spike statistics and inter-spike interval tracker.
//
// Watches one neuron's spike line and membrane state, and reports per-window
// statistics plus a running inter-spike interval (ISI).
//
// Window path:
//   A free-running counter cycles through 0..WIN_LEN-1. Over each window it
//   counts spike events (rising edges of spike, saturating at 255) and tracks
//   the unsigned maximum of state. On the last cycle of the window the totals
//   move into rate_out/peak_out, and out_valid is raised. The result is held
//   until the consumer accepts it with out_ready. If a new window ends while
//   a result is still unaccepted, the new totals replace it and the sticky
//   overrun flag is set.
//
// ISI path:
//   This is a two-state FSM (NO_SPIKE, TIMING) with an interval counter that
//   saturates at 255. Every event after the first one latches the interval
//   into isi_out and raises isi_valid. If that interval is shorter than
//   BURST_ISI, a one-cycle burst pulse is also produced. The ISI path ignores
//   window boundaries completely.
//
// Parameters:
//   WIN_LEN    window length in cycles (2..255)
//   BURST_ISI  an ISI below this value counts as a burst (1..254)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   spike      spike line (may be held high; only rising edges count)
//   state[7:0] membrane state, unsigned
//   out_ready  consumer accepts the window result this cycle
//   out_valid  a window result is pending
//   rate_out   spike count of the completed window
//   peak_out   maximum state seen in the completed window
//   isi_out    latest inter-spike interval, saturating at 255
//   isi_valid  isi_out holds a measured interval
//   burst      one-cycle pulse that marks a short-ISI event
//   overrun    sticky: a pending window result was overwritten
module spike_monitor #(
  parameter int WIN_LEN   = 100,
  parameter int BURST_ISI = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spike,
  input  logic [7:0] state,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] rate_out,
  output logic [7:0] peak_out,
  output logic [7:0] isi_out,
  output logic       isi_valid,
  output logic       burst,
  output logic       overrun
);

  localparam logic [7:0] WIN_LAST  = 8'(WIN_LEN - 1);
  localparam logic [7:0] BURST_THR = 8'(BURST_ISI);
  localparam logic [7:0] SAT       = 8'hFF;

  typedef enum logic {
    NO_SPIKE = 1'b0,
    TIMING   = 1'b1
  } isi_state_e;

  // ---------------------------------------------------------------------------
  // Spike edge detection
  // ---------------------------------------------------------------------------
  logic spike_q;
  logic spike_ev;

  // spike_q clears on reset. Because of that, a spike that is high on the
  // first cycle after reset is still seen as a rising edge.
  assign spike_ev = spike & ~spike_q;

  always_ff @(posedge clk) begin
    if (rst) spike_q <= 1'b0;
    else     spike_q <= spike;
  end

  // ---------------------------------------------------------------------------
  // Window accumulation
  // ---------------------------------------------------------------------------
  logic [7:0] win_cnt;
  logic [7:0] spk_cnt;
  logic [7:0] peak_q;
  logic       win_end;
  logic       handshake;
  logic [7:0] spk_cnt_inc;
  logic [7:0] peak_upd;

  assign win_end   = (win_cnt == WIN_LAST);
  assign handshake = out_valid & out_ready;

  // spk_cnt_inc and peak_upd already include the current cycle's event and
  // sample. This lets the window-end cycle publish its own contribution.
  assign spk_cnt_inc = (spike_ev && (spk_cnt != SAT)) ? spk_cnt + 8'd1 : spk_cnt;
  assign peak_upd    = (state > peak_q) ? state : peak_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      spk_cnt <= '0;
      peak_q  <= '0;
    end else if (win_end) begin
      win_cnt <= '0;
      spk_cnt <= '0;
      peak_q  <= '0;
    end else begin
      win_cnt <= win_cnt + 8'd1;
      spk_cnt <= spk_cnt_inc;
      peak_q  <= peak_upd;
    end
  end

  // ---------------------------------------------------------------------------
  // Result holding and handshake
  // ---------------------------------------------------------------------------
  // A window end always loads fresh totals, even if the previous result was
  // never accepted. The newest data wins, and overrun records the loss.
  // Outside a window end the outputs stay fixed, so they remain stable while
  // the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      rate_out  <= '0;
      peak_out  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (win_end) begin
        rate_out  <= spk_cnt_inc;
        peak_out  <= peak_upd;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ISI FSM
  // ---------------------------------------------------------------------------
  isi_state_e isi_st, isi_st_nxt;
  logic [7:0] isi_cnt, isi_cnt_nxt;
  logic       isi_load;
  logic       burst_nxt;

  always_ff @(posedge clk) begin
    if (rst) isi_st <= NO_SPIKE;
    else     isi_st <= isi_st_nxt;
  end

  always_comb begin
    isi_st_nxt  = isi_st;
    isi_cnt_nxt = isi_cnt;
    isi_load    = 1'b0;
    burst_nxt   = 1'b0;
    case (isi_st)
      NO_SPIKE: begin
        // The first event only starts timing. There is no interval to report
        // yet, so no burst can be produced here.
        if (spike_ev) begin
          isi_st_nxt  = TIMING;
          isi_cnt_nxt = 8'd1;
        end
      end
      TIMING: begin
        if (spike_ev) begin
          isi_load    = 1'b1;
          burst_nxt   = (isi_cnt < BURST_THR);
          isi_cnt_nxt = 8'd1;
        end else if (isi_cnt != SAT) begin
          isi_cnt_nxt = isi_cnt + 8'd1;
        end
      end
      default: isi_st_nxt = NO_SPIKE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      isi_cnt   <= '0;
      isi_out   <= '0;
      isi_valid <= 1'b0;
      burst     <= 1'b0;
    end else begin
      isi_cnt <= isi_cnt_nxt;
      burst   <= burst_nxt;
      if (isi_load) begin
        isi_out   <= isi_cnt;
        isi_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_monitor.sv
// Randomized and directed testbench for spike_monitor.
//
// The reference model works from absolute cycle numbers:
//   - Windows are located with modulo arithmetic.
//   - Each window's events and samples are queued, then summed and maxed
//     when the window ends.
//   - The ISI is the difference between the times of the last two events.
module tb_spike_monitor;
  localparam int WIN_LEN   = 10;
  localparam int BURST_ISI = 4;

  logic       clk = 1'b0;
  logic       rst, spike, out_ready;
  logic [7:0] state;
  logic       out_valid, isi_valid, burst, overrun;
  logic [7:0] rate_out, peak_out, isi_out;

  always #5 clk = ~clk;

  spike_monitor #(.WIN_LEN(WIN_LEN), .BURST_ISI(BURST_ISI)) dut (
    .clk(clk), .rst(rst), .spike(spike), .state(state), .out_ready(out_ready),
    .out_valid(out_valid), .rate_out(rate_out), .peak_out(peak_out),
    .isi_out(isi_out), .isi_valid(isi_valid), .burst(burst), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_t;                       // cycles since reset release
  bit  m_prev, m_have;
  int  m_last;                    // cycle of the most recent event
  int  q_ev[$];
  int  q_st[$];
  int  m_rate, m_peak, m_isi;
  bit  m_valid, m_isiv, m_burst, m_ovr;

  task automatic model_step(input bit r, input bit s, input int st, input bit rdy);
    bit ev, hs;
    int sum, mx;
    if (r) begin
      m_t = 0; m_prev = 0; m_have = 0; m_last = 0;
      q_ev.delete(); q_st.delete();
      m_rate = 0; m_peak = 0; m_isi = 0;
      m_valid = 0; m_isiv = 0; m_burst = 0; m_ovr = 0;
      return;
    end
    ev = s && !m_prev;
    m_prev = s;
    m_burst = 0;
    if (ev) begin
      if (m_have) begin
        m_isi   = (m_t - m_last > 255) ? 255 : m_t - m_last;
        m_isiv  = 1;
        m_burst = (m_isi < BURST_ISI);
      end
      m_have = 1;
      m_last = m_t;
    end
    q_ev.push_back(int'(ev));
    q_st.push_back(st);
    hs = m_valid && rdy;
    if (m_t % WIN_LEN == WIN_LEN - 1) begin
      sum = 0; mx = 0;
      foreach (q_ev[i]) sum += q_ev[i];
      foreach (q_st[i]) if (q_st[i] > mx) mx = q_st[i];
      if (m_valid && !hs) m_ovr = 1;
      m_rate  = (sum > 255) ? 255 : sum;
      m_peak  = mx;
      m_valid = 1;
      q_ev.delete(); q_st.delete();
    end else if (hs) begin
      m_valid = 0;
    end
    m_t++;
  endtask

  task automatic check_all();
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("rate_out",  int'(rate_out),  m_rate);
    chk("peak_out",  int'(peak_out),  m_peak);
    chk("isi_out",   int'(isi_out),   m_isi);
    chk("isi_valid", int'(isi_valid), int'(m_isiv));
    chk("burst",     int'(burst),     int'(m_burst));
    chk("overrun",   int'(overrun),   int'(m_ovr));
  endtask

  // One clock cycle: drive, edge, model, sample 1 ns after the edge.
  task automatic cyc(input bit r, input bit s, input int st, input bit rdy);
    rst = r; spike = s; state = st[7:0]; out_ready = rdy;
    @(posedge clk);
    model_step(r, s, st, rdy);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; spike = 1'b0; state = '0; out_ready = 1'b0;

    // Reset state
    repeat (3) cyc(1, 0, 0, 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_isiv",  int'(isi_valid), 0);

    // Pulses at cycles 2, 5, 9 in a 10-cycle window
    for (int i = 0; i < 10; i++) cyc(0, (i == 2 || i == 5 || i == 9), i * 3, 1);
    chk("win1_valid", int'(out_valid), 1);
    chk("win1_rate",  int'(rate_out), 3);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1);
    chk("win2_rate", int'(rate_out), 0);

    // Spike held high for 6 cycles
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, (i >= 1 && i <= 6), 5, 1);
      chk("hold_burst", int'(burst), 0);
    end
    chk("hold_rate", int'(rate_out), 1);

    // Events 3 cycles apart, then 300 apart
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, (i == 1 || i == 4), 0, 1);
    chk("isi3_val",   int'(isi_out), 3);
    chk("isi3_burst", int'(burst), 1);
    cyc(0, 0, 0, 1);
    chk("isi3_pulse", int'(burst), 0);
    for (int i = 0; i < 298; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    chk("isi_sat",       int'(isi_out), 255);
    chk("isi_sat_burst", int'(burst), 0);

    // Stalled consumer across two window ends
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 25; i++) cyc(0, ($urandom_range(0, 2) == 0), $urandom_range(0, 255), 0);
    chk("ovr_set",   int'(overrun), 1);
    chk("ovr_valid", int'(out_valid), 1);

    // Handshake only on window-end cycles: no overrun
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 30; i++)
      cyc(0, ($urandom_range(0, 2) == 0), $urandom_range(0, 255), (i % WIN_LEN == WIN_LEN - 1));
    chk("coinc_ovr",   int'(overrun), 0);
    chk("coinc_valid", int'(out_valid), 1);

    // State ramp to 200 then falling, then a lower window
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, (i < 9) ? i * 25 : 100, 1);
    chk("ramp_peak", int'(peak_out), 200);
    for (int i = 0; i < 10; i++) cyc(0, 0, $urandom_range(0, 150), 1);

    // Reset mid-window after 4 spikes
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, (i % 2 == 0), 50, 1);
    cyc(1, 0, 0, 1);
    chk("mid_rst_rate", int'(rate_out), 0);
    chk("mid_rst_isi",  int'(isi_out), 0);
    for (int i = 0; i < 10; i++) cyc(0, (i == 0 || i == 7), 9, 1);
    chk("post_rst_rate", int'(rate_out), 2);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit r;
      r = ($urandom_range(0, 599) == 0);
      if ((i / 400) % 3 == 2)
        cyc(r, ($urandom_range(0, 99) == 0), $urandom_range(0, 255), ($urandom_range(0, 9) < 7));
      else
        cyc(r, ($urandom_range(0, 2) == 0), $urandom_range(0, 255), ($urandom_range(0, 9) < 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
